// File: rtl/reggp_mp.sv
// ---------------------------------------------------------------------------
// reggp_mp : multi-ported general-purpose register file with a scoreboard.
//
// Two combinational read ports with same-cycle write bypass, two write ports
// (port 0 = ALU writeback, port 1 = load writeback, port 1 wins on a tie) and
// a per-register "pending" bit that an issue stage sets with a claim and a
// writeback clears. Busy flags tell the reader that a producer is in flight.
//
// Ports
//   iw_clk                       clock, all state on rising edge
//   iw_rst_n                     synchronous active-low reset
//   iw_read_addr1/2              read addresses
//   ow_read_data1/2              read data (combinational, bypassed)
//   ow_busy1/2                   addressed register still has a pending producer
//   iw_wr0_en/addr/data          write port 0
//   iw_wr1_en/addr/data          write port 1
//   iw_claim_en/addr             mark a register pending
//   ow_pend_cnt                  registered count of pending registers
//   ow_claim_err                 one-cycle pulse: claim hit an already-pending register
// ---------------------------------------------------------------------------
module reggp_mp #(
    parameter int DATA_W  = 24,
    parameter int NREG    = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic [ADDR_W-1:0] iw_read_addr1,
    input  logic [ADDR_W-1:0] iw_read_addr2,
    output logic [DATA_W-1:0] ow_read_data1,
    output logic [DATA_W-1:0] ow_read_data2,
    output logic              ow_busy1,
    output logic              ow_busy2,
    input  logic              iw_wr0_en,
    input  logic [ADDR_W-1:0] iw_wr0_addr,
    input  logic [DATA_W-1:0] iw_wr0_data,
    input  logic              iw_wr1_en,
    input  logic [ADDR_W-1:0] iw_wr1_addr,
    input  logic [DATA_W-1:0] iw_wr1_data,
    input  logic              iw_claim_en,
    input  logic [ADDR_W-1:0] iw_claim_addr,
    output logic [ADDR_W:0]   ow_pend_cnt,
    output logic              ow_claim_err
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pend;
    logic [CNT_W-1:0]  r_pend_cnt;
    logic              r_claim_err;

    logic              w_wr0_ok;
    logic              w_wr1_ok;
    logic              w_claim_ok;
    logic              w_claim_cleared;
    logic              w_claim_err_nxt;
    logic [NREG-1:0]   w_pend_nxt;
    logic [CNT_W-1:0]  w_pend_cnt_nxt;

    // Address 0 is invisible to every port when it is hardwired to zero.
    function automatic logic f_masked(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    // Bypassed read: the newest value wins, port 1 over port 0 over storage.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        if (f_masked(a))
            return '0;
        else if (w_wr1_ok && (iw_wr1_addr == a))
            return iw_wr1_data;
        else if (w_wr0_ok && (iw_wr0_addr == a))
            return iw_wr0_data;
        else
            return r_regs[a];
    endfunction

    // A writeback this cycle releases the register unless a new claim on the
    // same address re-arms it at the same edge.
    function automatic logic f_busy(input logic [ADDR_W-1:0] a);
        logic l_wr;
        logic l_cl;
        l_wr = (w_wr0_ok && (iw_wr0_addr == a)) || (w_wr1_ok && (iw_wr1_addr == a));
        l_cl = w_claim_ok && (iw_claim_addr == a);
        return !f_masked(a) && r_pend[a] && !(l_wr && !l_cl);
    endfunction

    assign w_wr0_ok   = iw_wr0_en   && !f_masked(iw_wr0_addr);
    assign w_wr1_ok   = iw_wr1_en   && !f_masked(iw_wr1_addr);
    assign w_claim_ok = iw_claim_en && !f_masked(iw_claim_addr);

    // A claim on a register whose producer retires this very cycle is a
    // legitimate re-issue, not a double claim.
    assign w_claim_cleared = (w_wr0_ok && (iw_wr0_addr == iw_claim_addr)) ||
                             (w_wr1_ok && (iw_wr1_addr == iw_claim_addr));
    assign w_claim_err_nxt = w_claim_ok && r_pend[iw_claim_addr] && !w_claim_cleared;

    always_comb begin
        ow_read_data1 = f_read(iw_read_addr1);
        ow_read_data2 = f_read(iw_read_addr2);
        ow_busy1      = f_busy(iw_read_addr1);
        ow_busy2      = f_busy(iw_read_addr2);
    end

    // Clears first, then the claim set so that a same-cycle claim wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr0_ok)
            w_pend_nxt[iw_wr0_addr] = 1'b0;
        if (w_wr1_ok)
            w_pend_nxt[iw_wr1_addr] = 1'b0;
        if (w_claim_ok)
            w_pend_nxt[iw_claim_addr] = 1'b1;
    end

    // Population count of the next pending vector; CNT_W bits hold NREG.
    always_comb begin
        w_pend_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            w_pend_cnt_nxt = w_pend_cnt_nxt + CNT_W'(w_pend_nxt[i]);
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_pend      <= '0;
            r_pend_cnt  <= '0;
            r_claim_err <= 1'b0;
        end else begin
            // Port 1 is assigned last so it wins on an address collision.
            if (w_wr0_ok)
                r_regs[iw_wr0_addr] <= iw_wr0_data;
            if (w_wr1_ok)
                r_regs[iw_wr1_addr] <= iw_wr1_data;
            r_pend      <= w_pend_nxt;
            r_pend_cnt  <= w_pend_cnt_nxt;
            r_claim_err <= w_claim_err_nxt;
        end
    end

    assign ow_pend_cnt  = r_pend_cnt;
    assign ow_claim_err = r_claim_err;

endmodule

// File: doc/reggp_mp.md
REGGP_MP -- requirements
Module: reggp_mp

Interface
REQ-001 Parameter DATA_W, default 24, register data width in bits.
REQ-002 Parameter NREG, default 16, number of registers (power of two, 2..64).
REQ-003 Parameter ADDR_W, default 4, address width; SHALL equal log2(NREG).
REQ-004 Parameter ZERO_R0, default 0; when 1, register 0 is hardwired to zero.
REQ-005 iw_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 iw_rst_n  in  1  reset, synchronous, active-low.
REQ-007 iw_read_addr1, iw_read_addr2  in  ADDR_W  read port addresses.
REQ-008 ow_read_data1, ow_read_data2  out  DATA_W  read data, combinational.
REQ-009 ow_busy1, ow_busy2  out  1  addressed register has a pending producer.
REQ-010 iw_wr0_en, iw_wr0_addr, iw_wr0_data  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback).
REQ-011 iw_wr1_en, iw_wr1_addr, iw_wr1_data  in  1/ADDR_W/DATA_W  write port 1 (load writeback).
REQ-012 iw_claim_en, iw_claim_addr  in  1/ADDR_W  mark register pending at issue.
REQ-013 ow_pend_cnt  out  ADDR_W+1  number of registers currently pending.
REQ-014 ow_claim_err  out  1  registered flag: claim attempted on an already-pending register.

Function
REQ-015 Storage SHALL be NREG x DATA_W registers plus an NREG-bit pending vector.
REQ-016 On a rising edge with wrN_en=1, register[wrN_addr] SHALL take wrN_data.
REQ-017 Both write ports enabled with equal address: port 1 data SHALL be stored.
REQ-018 Reads SHALL bypass same-cycle writes: if wrN_en and wrN_addr equals the read address, read data SHALL be wrN_data (port 1 over port 0), otherwise the stored value.
REQ-019 A write on either port SHALL clear the pending bit of its address at the same edge.
REQ-020 iw_claim_en=1 SHALL set pending[iw_claim_addr]; same-cycle claim and write to one address: the set SHALL win.
REQ-021 ow_busyN SHALL be pending[addrN] AND NOT (a same-cycle write to addrN with no same-cycle claim to addrN).
REQ-022 ow_pend_cnt SHALL be a registered counter equal to the population count of the pending vector after each edge; it SHALL never wrap (max NREG).
REQ-023 Claim on an address already pending and not cleared that cycle SHALL set ow_claim_err for exactly one cycle on the next edge; the pending bit stays 1 and the count is unchanged.
REQ-024 ZERO_R0=1: reads of address 0 SHALL return 0, writes and claims to 0 SHALL be ignored, ow_busyN SHALL be 0 for address 0, and no error SHALL be raised.
REQ-025 Latency: write-to-storage 1 edge; read path 0 cycles; busy/bypass same cycle.

Reset
REQ-026 iw_rst_n=0 at a rising edge SHALL clear all registers, the pending vector, ow_pend_cnt and ow_claim_err to 0, overriding same-cycle writes and claims.
REQ-027 During reset, outputs SHALL reflect the cleared state from the first edge with iw_rst_n low; reset mid-operation discards all pending claims.

Verification
REQ-028 Reset, then read all addresses -> ow_read_data=0, ow_busy=0, ow_pend_cnt=0.
REQ-029 wr0 addr 3 data 0x00ABCD with read_addr1=3 same cycle -> ow_read_data1=0x00ABCD before the edge and after it.
REQ-030 wr0 and wr1 both addr 5, data 0x111111 / 0x222222 -> read shows 0x222222 same cycle and after the edge.
REQ-031 Claim addr 7 -> next cycle ow_busy1=1 (read_addr1=7), pend_cnt=1; wr1 addr 7 -> busy=0 in the write cycle, pend_cnt=0 after.
REQ-032 Claim addr 7 twice without writeback -> ow_claim_err=1 for one cycle, pend_cnt stays 1; claim+write addr 7 same cycle -> pending stays 1.
REQ-033 ZERO_R0=1: write 0xFFFFFF to addr 0 and claim addr 0 -> read 0, busy 0, pend_cnt 0, claim_err 0; assert iw_rst_n low mid-sequence with 3 pending -> pend_cnt=0 next edge.
